// File: rtl/vx_branch_ctl_if.sv
// vx_branch_ctl_if: branch-issue, ALU resolution and PC-update signals between the scheduler/ALUs and the branch sink.
interface vx_branch_ctl_if #(
    parameter int NUM_BLOCKS = 2,
    parameter int NUM_WARPS  = 4,
    parameter int PC_BITS    = 32
);
    localparam int WID_BITS = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1;

    logic                           issue_valid;
    logic [WID_BITS-1:0]            issue_wid;
    logic [PC_BITS-1:0]             issue_npc;
    logic [NUM_BLOCKS-1:0]          ctl_valid;
    logic [NUM_BLOCKS*WID_BITS-1:0] ctl_wid;
    logic [NUM_BLOCKS-1:0]          ctl_taken;
    logic [NUM_BLOCKS*PC_BITS-1:0]  ctl_dest;
    logic                           upd_valid;
    logic [WID_BITS-1:0]            upd_wid;
    logic [PC_BITS-1:0]             upd_pc;
    logic                           upd_ready;
    logic [NUM_WARPS-1:0]           stalled_mask;
    logic                           error;

    modport master (
        output issue_valid, issue_wid, issue_npc, ctl_valid, ctl_wid, ctl_taken, ctl_dest, upd_ready,
        input  upd_valid, upd_wid, upd_pc, stalled_mask, error
    );

    modport slave (
        input  issue_valid, issue_wid, issue_npc, ctl_valid, ctl_wid, ctl_taken, ctl_dest, upd_ready,
        output upd_valid, upd_wid, upd_pc, stalled_mask, error
    );
endinterface

// File: rtl/vx_branch_ctl_sink.sv
// vx_branch_ctl_sink: per-warp branch tracking with round-robin ordered PC updates to the scheduler.
// Defining BRANCH_CTL_PERF_EN adds perf_taken / perf_not_taken resolution counters.
module vx_branch_ctl_sink #(
    parameter int NUM_BLOCKS = 2,
    parameter int NUM_WARPS  = 4,
    parameter int PC_BITS    = 32
) (
    input  logic clk,
    input  logic reset,
`ifdef BRANCH_CTL_PERF_EN
    output logic [31:0] perf_taken,
    output logic [31:0] perf_not_taken,
`endif
    vx_branch_ctl_if.slave bus
);
    localparam int WID_BITS = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1;

    typedef enum logic [1:0] {IDLE, PENDING, RESOLVED} state_e;

    state_e              state_q [NUM_WARPS];
    state_e              state_d [NUM_WARPS];
    logic [PC_BITS-1:0]  npc_q [NUM_WARPS];
    logic [PC_BITS-1:0]  npc_d [NUM_WARPS];
    logic [PC_BITS-1:0]  tgt_q [NUM_WARPS];
    logic [PC_BITS-1:0]  tgt_d [NUM_WARPS];
    logic [WID_BITS-1:0] rr_q, rr_d, lock_wid_q, lock_wid_d, pick, grant, cw;
    logic                lock_q, lock_d, error_q, error_d, any_res, fire, dup;
    int                  idx;
`ifdef BRANCH_CTL_PERF_EN
    logic [31:0]         perf_t_q, perf_t_d, perf_nt_q, perf_nt_d;
    assign perf_taken     = perf_t_q;
    assign perf_not_taken = perf_nt_q;
`endif

    always_comb begin
        pick    = rr_q;
        any_res = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = (int'(rr_q) + i) % NUM_WARPS;
            if (!any_res && state_q[idx] == RESOLVED) begin
                any_res = 1'b1;
                pick    = WID_BITS'(idx);
            end
        end
    end

    // A stalled offer keeps its warp until accepted; the locked warp stays RESOLVED meanwhile.
    assign grant          = lock_q ? lock_wid_q : pick;
    assign fire           = any_res && bus.upd_ready;
    assign bus.upd_valid  = any_res;
    assign bus.upd_wid    = any_res ? grant : '0;
    assign bus.upd_pc     = any_res ? tgt_q[grant] : '0;
    assign bus.error      = error_q;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_stall
        assign bus.stalled_mask[w] = state_q[w] != IDLE;
    end

    always_comb begin
        state_d    = state_q;
        npc_d      = npc_q;
        tgt_d      = tgt_q;
        rr_d       = rr_q;
        lock_d     = any_res && !bus.upd_ready;
        lock_wid_d = grant;
        error_d    = 1'b0;
        dup        = 1'b0;
        cw         = '0;
`ifdef BRANCH_CTL_PERF_EN
        perf_t_d   = perf_t_q;
        perf_nt_d  = perf_nt_q;
`endif
        if (bus.issue_valid) begin
            if (state_q[bus.issue_wid] == IDLE) begin
                state_d[bus.issue_wid] = PENDING;
                npc_d[bus.issue_wid]   = bus.issue_npc;
            end else
                error_d = 1'b1;
        end
        // Lowest block wins a duplicated wid; later duplicates only flag an error.
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            cw  = bus.ctl_wid[b*WID_BITS +: WID_BITS];
            dup = 1'b0;
            for (int c = 0; c < b; c++)
                dup = dup | (bus.ctl_valid[c] && bus.ctl_wid[c*WID_BITS +: WID_BITS] == cw);
            if (bus.ctl_valid[b]) begin
                if (dup || state_q[cw] != PENDING)
                    error_d = 1'b1;
                else begin
                    state_d[cw] = RESOLVED;
                    tgt_d[cw]   = bus.ctl_taken[b] ? bus.ctl_dest[b*PC_BITS +: PC_BITS] : npc_q[cw];
`ifdef BRANCH_CTL_PERF_EN
                    perf_t_d    = perf_t_d + {31'd0, bus.ctl_taken[b]};
                    perf_nt_d   = perf_nt_d + {31'd0, !bus.ctl_taken[b]};
`endif
                end
            end
        end
        if (fire) begin
            state_d[grant] = IDLE;
            rr_d           = (grant == WID_BITS'(NUM_WARPS - 1)) ? '0 : grant + WID_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= IDLE;
                npc_q[w]   <= '0;
                tgt_q[w]   <= '0;
            end
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_wid_q <= '0;
            error_q    <= 1'b0;
`ifdef BRANCH_CTL_PERF_EN
            perf_t_q   <= '0;
            perf_nt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            npc_q      <= npc_d;
            tgt_q      <= tgt_d;
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_wid_q <= lock_wid_d;
            error_q    <= error_d;
`ifdef BRANCH_CTL_PERF_EN
            perf_t_q   <= perf_t_d;
            perf_nt_q  <= perf_nt_d;
`endif
        end
    end
endmodule

// File: tb/tb_vx_branch_ctl_sink.sv
// tb_vx_branch_ctl_sink: directed bench with a per-cycle reference model of vx_branch_ctl_sink.
// Honours BRANCH_CTL_PERF_EN when defined.
module tb_vx_branch_ctl_sink;
    localparam int NB = 2;
    localparam int NW = 4;
    localparam int WB = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
`ifdef BRANCH_CTL_PERF_EN
    logic [31:0] perf_taken, perf_not_taken;
`endif

    vx_branch_ctl_if #(.NUM_BLOCKS(NB), .NUM_WARPS(NW), .PC_BITS(32)) bus ();

    vx_branch_ctl_sink #(.NUM_BLOCKS(NB), .NUM_WARPS(NW), .PC_BITS(32)) dut (
        .clk(clk),
        .reset(reset),
`ifdef BRANCH_CTL_PERF_EN
        .perf_taken(perf_taken),
        .perf_not_taken(perf_not_taken),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: a warp is "waiting" between issue and resolution, "done" until its update is taken.
    bit          m_waiting [NW];
    bit          m_done [NW];
    bit          ow [NW];
    bit          claimed [NW];
    logic [31:0] m_npc [NW];
    logic [31:0] m_tgt [NW];
    int          m_ptr, m_hold_w, mg, cg, iw, cw;
    bit          m_hold, m_err;
    logic [31:0] m_pt, m_pnt;
    logic [NW-1:0] e_stall;

    function automatic int pick();
        if (m_hold) return m_hold_w;
        for (int k = 0; k < NW; k++)
            if (m_done[(m_ptr + k) % NW]) return (m_ptr + k) % NW;
        return -1;
    endfunction

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NW; w++) begin
                m_waiting[w] = 0; m_done[w] = 0; m_npc[w] = 0; m_tgt[w] = 0;
            end
            m_ptr = 0; m_hold = 0; m_hold_w = 0; m_err = 0; m_pt = 0; m_pnt = 0;
        end else begin
            mg = pick();
            m_err = 0;
            for (int w = 0; w < NW; w++) begin
                ow[w] = m_waiting[w] || m_done[w] ? m_waiting[w] : 0;
                claimed[w] = 0;
            end
            if (bus.issue_valid) begin
                iw = int'(bus.issue_wid);
                if (m_waiting[iw] || m_done[iw]) m_err = 1;
                else begin
                    m_waiting[iw] = 1;
                    m_npc[iw] = bus.issue_npc;
                end
            end
            for (int b = 0; b < NB; b++) begin
                if (bus.ctl_valid[b]) begin
                    cw = int'(bus.ctl_wid[b*WB +: WB]);
                    if (claimed[cw] || !ow[cw]) m_err = 1;
                    else begin
                        m_waiting[cw] = 0;
                        m_done[cw] = 1;
                        m_tgt[cw] = bus.ctl_taken[b] ? bus.ctl_dest[b*32 +: 32] : m_npc[cw];
                        if (bus.ctl_taken[b]) m_pt = m_pt + 1; else m_pnt = m_pnt + 1;
                    end
                    claimed[cw] = 1;
                end
            end
            if (mg >= 0 && bus.upd_ready) begin
                m_done[mg] = 0;
                m_ptr = (mg + 1) % NW;
                m_hold = 0;
            end else begin
                m_hold = mg >= 0;
                m_hold_w = mg < 0 ? 0 : mg;
            end
        end
    end

    always @(negedge clk) begin
        cg = pick();
        for (int w = 0; w < NW; w++) e_stall[w] = m_waiting[w] | m_done[w];
        chk("upd_valid", 64'(bus.upd_valid), 64'(cg >= 0));
        chk("upd_wid", 64'(bus.upd_wid), cg >= 0 ? 64'(cg) : 64'd0);
        chk("upd_pc", 64'(bus.upd_pc), cg >= 0 ? 64'(m_tgt[cg]) : 64'd0);
        chk("stalled_mask", 64'(bus.stalled_mask), 64'(e_stall));
        chk("error", 64'(bus.error), 64'(m_err));
`ifdef BRANCH_CTL_PERF_EN
        chk("perf_taken", 64'(perf_taken), 64'(m_pt));
        chk("perf_not_taken", 64'(perf_not_taken), 64'(m_pnt));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        bus.ctl_valid = '0;
    endtask

    task automatic iss(int w, logic [31:0] pc);
        bus.issue_valid = 1'b1;
        bus.issue_wid = WB'(w);
        bus.issue_npc = pc;
    endtask

    task automatic ctl(int b, int w, bit t, logic [31:0] d);
        bus.ctl_valid[b] = 1'b1;
        bus.ctl_wid[b*WB +: WB] = WB'(w);
        bus.ctl_taken[b] = t;
        bus.ctl_dest[b*32 +: 32] = d;
    endtask

    task automatic lit(string n, bit v, int w, logic [31:0] pc, logic [NW-1:0] st, bit er);
        chk({n, "_valid"}, 64'(bus.upd_valid), 64'(v));
        chk({n, "_wid"}, 64'(bus.upd_wid), 64'(w));
        chk({n, "_pc"}, 64'(bus.upd_pc), 64'(pc));
        chk({n, "_stall"}, 64'(bus.stalled_mask), 64'(st));
        chk({n, "_err"}, 64'(bus.error), 64'(er));
    endtask

    initial begin
        bus.issue_valid = 0; bus.issue_wid = '0; bus.issue_npc = '0;
        bus.ctl_valid = '0; bus.ctl_wid = '0; bus.ctl_taken = '0; bus.ctl_dest = '0;
        bus.upd_ready = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        lit("reset", 0, 0, 32'h0, 4'b0000, 0);
        // parallel resolution from both blocks, RR order w0 then w3
        iss(0, 32'h100); cyc();
        iss(3, 32'h300); cyc();
        lit("par_issue", 0, 0, 32'h0, 4'b1001, 0);
        ctl(0, 0, 1, 32'h400); ctl(1, 3, 1, 32'h430); cyc();
        lit("par_first", 1, 0, 32'h400, 4'b1001, 0); cyc();
        lit("par_second", 1, 3, 32'h430, 4'b1000, 0); cyc();
        lit("par_done", 0, 0, 32'h0, 4'b0000, 0);
        // single taken
        iss(2, 32'h104); cyc();
        lit("tk_issue", 0, 0, 32'h0, 4'b0100, 0);
        ctl(0, 2, 1, 32'h200); cyc();
        lit("tk_upd", 1, 2, 32'h200, 4'b0100, 0); cyc();
        lit("tk_done", 0, 0, 32'h0, 4'b0000, 0);
        // single not taken
        iss(1, 32'h88); cyc();
        ctl(0, 1, 0, 32'h300); cyc();
        lit("nt_upd", 1, 1, 32'h88, 4'b0010, 0); cyc();
        // backpressure with three resolved warps
        bus.upd_ready = 1'b0;
        iss(0, 32'h500); cyc();
        iss(1, 32'h600); cyc();
        iss(3, 32'h700); cyc();
        ctl(0, 0, 1, 32'h510); ctl(1, 1, 0, 32'h999); cyc();
        ctl(0, 3, 1, 32'h710); cyc();
        for (int i = 0; i < 5; i++) begin
            lit("bp_hold", 1, 0, 32'h510, 4'b1011, 0); cyc();
        end
        bus.upd_ready = 1'b1;
        lit("bp_f0", 1, 0, 32'h510, 4'b1011, 0); cyc();
        lit("bp_f1", 1, 1, 32'h600, 4'b1010, 0); cyc();
        lit("bp_f2", 1, 3, 32'h710, 4'b1000, 0); cyc();
        lit("bp_done", 0, 0, 32'h0, 4'b0000, 0);
        // resolution for an idle warp
        ctl(0, 2, 1, 32'h123); cyc();
        lit("err_idle", 0, 0, 32'h0, 4'b0000, 1); cyc();
        lit("err_clear", 0, 0, 32'h0, 4'b0000, 0);
        // duplicate wid from both blocks: block 0 wins
        iss(2, 32'h50); cyc();
        ctl(0, 2, 1, 32'h10); ctl(1, 2, 1, 32'h20); cyc();
        lit("dup", 1, 2, 32'h10, 4'b0100, 1); cyc();
        // reissue to a pending warp must not disturb its npc
        iss(1, 32'h60); cyc();
        iss(1, 32'h70); cyc();
        lit("err_reissue", 0, 0, 32'h0, 4'b0010, 1);
        ctl(1, 1, 0, 32'h0); cyc();
        lit("reissue_upd", 1, 1, 32'h60, 4'b0010, 0); cyc();
        // issue in the same cycle the warp's update fires
        iss(0, 32'h80); cyc();
        bus.upd_ready = 1'b0;
        ctl(0, 0, 1, 32'h90); cyc();
        lit("fire_iss_pre", 1, 0, 32'h90, 4'b0001, 0);
        bus.upd_ready = 1'b1;
        iss(0, 32'hA0); cyc();
        lit("fire_iss", 0, 0, 32'h0, 4'b0000, 1);
        // reset mid-flight, with traffic presented during reset
        bus.upd_ready = 1'b0;
        iss(1, 32'h11); cyc();
        iss(2, 32'h22); cyc();
        ctl(0, 1, 1, 32'h111); ctl(1, 2, 0, 32'h0); cyc();
        lit("rst_pre", 1, 1, 32'h111, 4'b0110, 0);
        reset = 1'b1;
        ctl(0, 3, 1, 32'h333); iss(3, 32'h3); cyc();
        reset = 1'b0;
        lit("rst_post", 0, 0, 32'h0, 4'b0000, 0);
`ifdef BRANCH_CTL_PERF_EN
        chk("rst_perf_t", 64'(perf_taken), 64'd0);
        chk("rst_perf_nt", 64'(perf_not_taken), 64'd0);
`endif
        iss(3, 32'h44); cyc();
        ctl(1, 3, 1, 32'h55); cyc();
        bus.upd_ready = 1'b1;
        lit("after_rst", 1, 3, 32'h55, 4'b1000, 0); cyc();
        lit("end", 0, 0, 32'h0, 4'b0000, 0);
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
